// File: rtl/ks_operand_sequencer.sv
`default_nettype none
// ============================================================================
// ks_operand_sequencer: valid/ready operand collector and result register
// stage around the Kogge-Stone adder core.  Revision 1.0
// ============================================================================
module ks_operand_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_acc,
   input  logic             acc_clear,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             acc_ovf,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GET_B = 2'd1;
   localparam logic [1:0] S_ADD   = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc;
   logic             mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc       <= '0;
         mode      <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_valid <= 1'b0;
         acc_ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (in_acc) begin
                     // Accumulate op: the single beat is operand B, A comes from acc.
                     b_reg <= in_data;
                     mode  <= 1'b1;
                     state <= S_ADD;
                  end else begin
                     a_reg <= in_data;
                     mode  <= 1'b0;
                     state <= S_GET_B;
                  end
               end
            end
            S_GET_B: begin
               if (in_valid) begin
                  b_reg <= in_data;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               out_sum   <= add_sum;
               out_cout  <= add_cout;
               acc       <= add_sum;
               out_valid <= 1'b1;
               if (mode && add_cout) begin
                  acc_ovf <= 1'b1;
               end
               state <= S_RESP;
            end
            default: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
         endcase

         // Placed last so a clear on the ADD edge overrides the acc/acc_ovf update.
         if (acc_clear) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
         end
      end
   end

   assign in_ready = (state == S_IDLE) || (state == S_GET_B);
   assign busy     = (state != S_IDLE);
   assign add_a    = mode ? acc : a_reg;
   assign add_b    = b_reg;

endmodule
`default_nettype wire
